// File: rtl/mdu_pipe_if.sv
// mdu_pipe_if: Execute-stage bundle between the pipeline and the MDU.
//   start, op, a, b, req : pipeline -> MDU (op request, operands, flush)
//   busy, done, hi, lo   : MDU -> pipeline (stall, completion pulse, HI/LO)
// master = pipeline side, slave = MDU side.
interface mdu_pipe_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             req;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, req,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, req,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_pipe.sv
// mdu_pipe: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mdu_pipe_if slave (start/op/a/b/req in, busy/done/hi/lo out)
// Multiplies (incl. MADD/MSUB) take MULT_LAT busy cycles, divides WIDTH+1
// (WIDTH restoring steps plus a sign-fix cycle). MTHI/MTLO write in one edge.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no op in flight, accepts new ops, MTHI/MTLO write here
// MUL      | counting down multiply latency, result written at cnt==0
// DIV_ITER | one restoring step per cycle on operand magnitudes
// DIV_FIX  | apply signs / special cases and write HI/LO
module mdu_pipe #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5
) (
   input  logic         clk,
   input  logic         reset,
   mdu_pipe_if.slave    bus
);
   localparam int CNT_MAX = (MULT_LAT > WIDTH) ? MULT_LAT : WIDTH;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int W2      = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] quot, rem, dvs;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             busy_q, done_q;

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   // Operand magnitudes taken at the accept edge; odd opcodes are unsigned.
   logic             in_sgn;
   logic [WIDTH-1:0] mag_a, mag_b;
   assign in_sgn = ~bus.op[0];
   assign mag_a  = (in_sgn & bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign mag_b  = (in_sgn & bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // Multiply path: sign/zero-extend to 2*WIDTH so one multiplier covers both.
   logic          q_sgn;
   logic [W2-1:0] a_ext, b_ext, prod, mul_res;
   assign q_sgn = ~op_q[0];
   assign a_ext = {{WIDTH{q_sgn & a_q[WIDTH-1]}}, a_q};
   assign b_ext = {{WIDTH{q_sgn & b_q[WIDTH-1]}}, b_q};
   assign prod  = a_ext * b_ext;

   always_comb begin
      mul_res = prod;
      case (op_q[2:1])
         2'b10:   mul_res = {hi_q, lo_q} + prod;
         2'b11:   mul_res = {hi_q, lo_q} - prod;
         default: mul_res = prod;
      endcase
   end

   // Restoring step. The shifted remainder is WIDTH+1 bits; when its top bit
   // is set it exceeds any divisor, and the difference still fits WIDTH bits.
   logic [WIDTH-1:0] rem_low, rem_nx, quot_nx;
   logic             rem_top, ge;
   assign rem_top = rem[WIDTH-1];
   assign rem_low = {rem[WIDTH-2:0], quot[WIDTH-1]};
   assign ge      = rem_top | (rem_low >= dvs);
   assign rem_nx  = ge ? (rem_low - dvs) : rem_low;
   assign quot_nx = {quot[WIDTH-2:0], ge};

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] q_res, r_res;
   assign a_neg = q_sgn & a_q[WIDTH-1];
   assign b_neg = q_sgn & b_q[WIDTH-1];
   assign q_res = (a_neg ^ b_neg) ? -quot : quot;
   assign r_res = a_neg ? -rem : rem;

   // HI/LO are only written on completion, so they double as the restore
   // copy: a cancel simply skips the write and the pre-op values remain.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         quot   <= '0;
         rem    <= '0;
         dvs    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     case (bus.op)
                        4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
                           op_q   <= bus.op[2:0];
                           a_q    <= bus.a;
                           b_q    <= bus.b;
                           cnt    <= CW'(MULT_LAT - 1);
                           busy_q <= 1'b1;
                           state  <= MUL;
                        end
                        4'd2, 4'd3: begin
                           op_q   <= bus.op[2:0];
                           a_q    <= bus.a;
                           b_q    <= bus.b;
                           quot   <= mag_a;
                           dvs    <= mag_b;
                           rem    <= '0;
                           cnt    <= CW'(WIDTH - 1);
                           busy_q <= 1'b1;
                           state  <= DIV_ITER;
                        end
                        4'd8:    hi_q <= bus.a;
                        4'd9:    lo_q <= bus.a;
                        default: ;
                     endcase
                  end
               end
               MUL: begin
                  if (cnt == '0) begin
                     {hi_q, lo_q} <= mul_res;
                     busy_q       <= 1'b0;
                     done_q       <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               DIV_ITER: begin
                  quot <= quot_nx;
                  rem  <= rem_nx;
                  if (cnt == '0) state <= DIV_FIX;
                  else           cnt   <= cnt - 1'b1;
               end
               DIV_FIX: begin
                  if (b_q == '0) begin
                     lo_q <= '1;
                     hi_q <= a_q;
                  end else begin
                     lo_q <= q_res;
                     hi_q <= r_res;
                  end
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mdu_pipe.sv
// tb_mdu_pipe: directed self-checking bench for mdu_pipe (WIDTH=32, MULT_LAT=5).
module tb_mdu_pipe;
   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   mdu_pipe_if #(.WIDTH(32)) bus ();

   mdu_pipe #(.WIDTH(32), .MULT_LAT(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts negedges with busy high; flags any overlap with done.
   task automatic wait_idle(output int n, output logic both);
      n    = 0;
      both = 1'b0;
      while (bus.busy === 1'b1 && n < 100) begin
         if (bus.done === 1'b1) both = 1'b1;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run(input string tag, input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y, input int lat,
                      input logic [31:0] eh, input logic [31:0] el);
      int   n;
      logic both;
      issue(o, x, y);
      wait_idle(n, both);
      check({tag, " lat"}, n, lat);
      check({tag, " busy&done"}, {31'd0, both}, 32'd0);
      check({tag, " done"}, {31'd0, bus.done}, 32'd1);
      check({tag, " hi"}, bus.hi, eh);
      check({tag, " lo"}, bus.lo, el);
      @(negedge clk);
      check({tag, " done1"}, {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      int   n;
      logic both;
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 4'd0;
      bus.a     = '0;
      bus.b     = '0;
      bus.req   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst busy", {31'd0, bus.busy}, 32'd0);
      check("rst done", {31'd0, bus.done}, 32'd0);
      check("rst hi", bus.hi, 32'd0);
      check("rst lo", bus.lo, 32'd0);
      reset = 1'b0;

      // multiply latency / sign
      run("mult",  4'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run("multu", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
      // divide latency / sign
      run("div",   4'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run("divu",  4'd3, 32'hFFFF_FFF9, 32'd2, 33, 32'h0000_0001, 32'h7FFF_FFFC);
      // divide edge cases
      run("divu0", 4'd3, 32'h0000_1234, 32'd0, 33, 32'h0000_1234, 32'hFFFF_FFFF);
      run("divmin", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

      // accumulate
      issue(4'd8, 32'd5, 32'd0);
      check("mthi", bus.hi, 32'd5);
      check("mthi busy", {31'd0, bus.busy}, 32'd0);
      issue(4'd9, 32'd7, 32'd0);
      check("mtlo", bus.lo, 32'd7);
      run("maddu", 4'd5, 32'd2, 32'd3, 5, 32'd5, 32'h0000_000D);
      run("msub",  4'd6, 32'd1, 32'd1, 5, 32'd5, 32'h0000_000C);
      issue(4'd8, 32'd0, 32'd0);
      run("msub2", 4'd6, 32'd1, 32'h0000_000D, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // cancel mid-divide
      issue(4'd8, 32'h11, 32'd0);
      issue(4'd9, 32'h22, 32'd0);
      issue(4'd2, 32'd1000, 32'd7);
      repeat (9) @(negedge clk);
      bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      check("cancel busy", {31'd0, bus.busy}, 32'd0);
      check("cancel done", {31'd0, bus.done}, 32'd0);
      check("cancel hi", bus.hi, 32'h11);
      check("cancel lo", bus.lo, 32'h22);
      repeat (40) @(negedge clk);
      check("cancel late done", {31'd0, bus.done}, 32'd0);
      check("cancel late lo", bus.lo, 32'h22);

      // MTLO dropped by req
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 4'd9;
      bus.a     = 32'h99;
      bus.req   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.req   = 1'b0;
      check("mtlo req", bus.lo, 32'h22);

      // req on the MULT completion edge
      issue(4'd0, 32'd3, 32'd4);
      repeat (4) @(negedge clk);
      bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      check("mreq busy", {31'd0, bus.busy}, 32'd0);
      check("mreq done", {31'd0, bus.done}, 32'd0);
      check("mreq hi", bus.hi, 32'h11);
      check("mreq lo", bus.lo, 32'h22);

      // start while busy is ignored
      issue(4'd2, 32'd100, 32'd7);
      bus.start = 1'b1;
      bus.op    = 4'd0;
      bus.a     = 32'd5;
      bus.b     = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle(n, both);
      check("illegal lat", n + 1, 33);
      check("illegal hi", bus.hi, 32'd2);
      check("illegal lo", bus.lo, 32'd14);
      @(negedge clk);

      // reset mid-divide, then immediate MULT
      issue(4'd2, 32'd50, 32'd3);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mrst busy", {31'd0, bus.busy}, 32'd0);
      check("mrst hi", bus.hi, 32'd0);
      check("mrst lo", bus.lo, 32'd0);
      reset     = 1'b0;
      bus.start = 1'b1;
      bus.op    = 4'd0;
      bus.a     = 32'd6;
      bus.b     = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      check("post busy", {31'd0, bus.busy}, 32'd1);
      wait_idle(n, both);
      check("post lat", n, 5);
      check("post hi", bus.hi, 32'd0);
      check("post lo", bus.lo, 32'd42);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
